// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: value/load inputs and scanned display
// outputs of the seven-segment driver.
interface seg_scan_driver_if #(
  parameter int NUM_PAIRS = 3
);
  logic [6*NUM_PAIRS-1:0] values;
  logic                   set24hours;
  logic                   load;
  logic [NUM_PAIRS-1:0]   blink_mask;
  logic                   busy;
  logic                   pm;
  logic [6:0]             seg;
  logic [2*NUM_PAIRS-1:0] an;

  modport master (
    output values, set24hours, load, blink_mask,
    input  busy, pm, seg, an
  );

  modport slave (
    input  values, set24hours, load, blink_mask,
    output busy, pm, seg, an
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 12/24h mapping, serial double-dabble and
// time-multiplexed seven-segment scan for the alarm clock.
module seg_scan_driver #(
  parameter int NUM_PAIRS   = 3,
  parameter int HOURS_PAIR  = 2,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input logic clk,
  input logic reset,
  seg_scan_driver_if.slave bus
);
  localparam int ND = 2 * NUM_PAIRS;
  localparam int VW = 6 * NUM_PAIRS;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  typedef enum logic [1:0] {
    IDLE, ADJUST, CONVERT, COMMIT
  } state_t;

  state_t               state;
  logic [VW-1:0]        cap_vals;
  logic [VW-1:0]        adj_vals;
  logic [VW-1:0]        adj_next;
  logic                 cap_24;
  logic [NUM_PAIRS-1:0] sh_inv;
  logic [NUM_PAIRS-1:0] inv_next;
  logic [NUM_PAIRS-1:0] disp_inv;
  logic                 sh_pm;
  logic                 pm_next;
  logic                 disp_pm;
  logic                 disp_24;
  logic                 busy_q;
  logic [PW-1:0]        pair_idx;
  logic [2:0]           bit_cnt;
  logic [5:0]           hv;
  logic [5:0]           hadj;
  logic [5:0]           sh_bin;
  logic [5:0]           cur_bin;
  logic [5:0]           nxt_bin;
  logic [7:0]           sh_bcd;
  logic [7:0]           cur_bcd;
  logic [7:0]           cor_bcd;
  logic [7:0]           nxt_bcd;
  logic [4*ND-1:0]      sh_digits;
  logic [4*ND-1:0]      disp_digits;

  logic [RW-1:0]        rcnt;
  logic [BW-1:0]        bcnt;
  logic [IW-1:0]        idx;
  logic                 blink_phase;
  logic [6:0]           seg_q;
  logic [ND-1:0]        an_q;
  logic [6:0]           seg_next;
  logic [ND-1:0]        an_next;
  logic [3:0]           dig;
  logic                 tens;
  logic                 lz;
  int                   pr;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Hours mapping; only the hours pair is rewritten.
  always_comb begin
    adj_next = cap_vals;
    pm_next  = 1'b0;
    hv       = cap_vals[6*HOURS_PAIR +: 6];
    hadj     = hv;
    if (cap_24) begin
      if (hv == 6'd24)
        hadj = 6'd0;
    end else begin
      unique case (1'b1)
        (hv == 6'd0): hadj = 6'd12;
        (hv == 6'd12): pm_next = 1'b1;
        (hv > 6'd12 && hv < 6'd24): begin
          hadj    = hv - 6'd12;
          pm_next = 1'b1;
        end
        default: ;
      endcase
    end
    adj_next[6*HOURS_PAIR +: 6] = hadj;
    for (int p = 0; p < NUM_PAIRS; p++)
      inv_next[p] = adj_next[6*p +: 6] > 6'd59;
  end

  // One shift-add-3 step; bit_cnt==0 starts a fresh pair.
  always_comb begin
    cur_bin = (bit_cnt == 3'd0)
            ? adj_vals[6*int'(pair_idx) +: 6]
            : sh_bin;
    cur_bcd = (bit_cnt == 3'd0) ? 8'd0 : sh_bcd;
    cor_bcd = cur_bcd;
    if (cur_bcd[3:0] >= 4'd5)
      cor_bcd[3:0] = cur_bcd[3:0] + 4'd3;
    if (cur_bcd[7:4] >= 4'd5)
      cor_bcd[7:4] = cur_bcd[7:4] + 4'd3;
    nxt_bcd = (cor_bcd << 1) | {7'd0, cur_bin[5]};
    nxt_bin = cur_bin << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      cap_vals    <= '0;
      cap_24      <= 1'b0;
      adj_vals    <= '0;
      sh_inv      <= '0;
      sh_pm       <= 1'b0;
      pair_idx    <= '0;
      bit_cnt     <= '0;
      sh_bin      <= '0;
      sh_bcd      <= '0;
      sh_digits   <= '0;
      disp_digits <= '0;
      disp_inv    <= '0;
      disp_pm     <= 1'b0;
      disp_24     <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.load) begin
            cap_vals <= bus.values;
            cap_24   <= bus.set24hours;
            state    <= ADJUST;
          end
        end
        ADJUST: begin
          adj_vals <= adj_next;
          sh_inv   <= inv_next;
          sh_pm    <= pm_next;
          pair_idx <= '0;
          bit_cnt  <= '0;
          busy_q   <= 1'b1;
          state    <= CONVERT;
        end
        CONVERT: begin
          sh_bin <= nxt_bin;
          sh_bcd <= nxt_bcd;
          if (bit_cnt == 3'd5) begin
            sh_digits[8*int'(pair_idx) +: 8] <= nxt_bcd;
            bit_cnt <= '0;
            if (pair_idx == PW'(NUM_PAIRS - 1))
              state <= COMMIT;
            else
              pair_idx <= pair_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        COMMIT: begin
          disp_digits <= sh_digits;
          disp_inv    <= sh_inv;
          disp_pm     <= sh_pm;
          disp_24     <= cap_24;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pr       = int'(idx) / 2;
    tens     = idx[0];
    dig      = disp_digits[4*int'(idx) +: 4];
    lz       = tens && (pr == HOURS_PAIR) &&
               !disp_24 && (dig == 4'd0);
    seg_next = 7'h7F;
    an_next  = '1;
    if (blink_phase && bus.blink_mask[pr]) begin
      seg_next = 7'h7F;
    end else if (disp_inv[pr]) begin
      seg_next = 7'h3F;
      an_next  = ~(ND'(1) << idx);
    end else if (!lz) begin
      seg_next = seg_of(dig);
      an_next  = ~(ND'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt        <= '0;
      bcnt        <= '0;
      idx         <= '0;
      blink_phase <= 1'b0;
      seg_q       <= 7'h7F;
      an_q        <= '1;
    end else begin
      if (rcnt == RW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        idx  <= (idx == IW'(ND - 1)) ? '0 : idx + 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
      if (bcnt == BW'(BLINK_DIV - 1)) begin
        bcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
      seg_q <= seg_next;
      an_q  <= an_next;
    end
  end

  assign bus.busy = busy_q;
  assign bus.pm   = disp_pm;
  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed loads against an arithmetic
// display model checked on every clock.
module tb_seg_scan_driver;
  localparam int NP = 3;
  localparam int HP = 2;
  localparam int RD = 4;
  localparam int BD = 16;
  localparam int ND = 2 * NP;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seg_scan_driver_if #(.NUM_PAIRS(NP)) bus ();

  seg_scan_driver #(
    .NUM_PAIRS(NP),
    .HOURS_PAIR(HP),
    .REFRESH_DIV(RD),
    .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] pat [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int  m_dig [ND];
  bit  m_inv [NP];
  bit  m_pm, m_24;
  int  p_dig [ND];
  bit  p_inv [NP];
  bit  p_pm, p_24;
  bit  pend, started, committed;
  int  k, acc_k, cmt_k;
  int  e_idx, e_ph, e_pr;
  logic [6:0]  e_seg;
  logic [ND-1:0] e_an;
  bit  e_busy, e_pm;
  bit  s_r, s_ld, s_24;
  logic [6*NP-1:0] s_vals;
  logic [NP-1:0]   s_msk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic [6*NP-1:0] pack(int h, int m, int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  function automatic void model_load(logic [6*NP-1:0] v, bit s24);
    p_pm = 0;
    p_24 = s24;
    for (int p = 0; p < NP; p++) begin
      int x;
      x = int'(v[6*p +: 6]);
      if (p == HP) begin
        if (s24) begin
          if (x == 24) x = 0;
        end else if (x == 0) begin
          x = 12;
        end else if (x >= 12 && x < 24) begin
          p_pm = 1;
          if (x > 12) x = x - 12;
        end
      end
      p_inv[p] = x > 59;
      p_dig[2*p] = x % 10;
      p_dig[2*p+1] = x / 10;
    end
  endfunction

  always @(posedge clk) begin
    s_r = reset;
    s_ld = bus.load;
    s_24 = bus.set24hours;
    s_vals = bus.values;
    s_msk = bus.blink_mask;
    #1;
    if (s_r) begin
      started = 1;
      k = 0;
      for (int i = 0; i < ND; i++) m_dig[i] = 0;
      for (int i = 0; i < NP; i++) m_inv[i] = 0;
      m_pm = 0;
      m_24 = 1;
      pend = 0;
      e_seg = 7'h7F;
      e_an = '1;
      e_busy = 0;
      e_pm = 0;
    end else if (started) begin
      k++;
      e_idx = ((k - 1) / RD) % ND;
      e_ph = ((k - 1) / BD) % 2;
      e_pr = e_idx / 2;
      e_seg = 7'h7F;
      e_an = '1;
      if (e_ph == 1 && s_msk[e_pr]) begin
        e_seg = 7'h7F;
      end else if (m_inv[e_pr]) begin
        e_seg = 7'h3F;
        e_an = ~(ND'(1) << e_idx);
      end else if (!(e_idx % 2 == 1 && e_pr == HP && !m_24 &&
                     m_dig[e_idx] == 0)) begin
        e_seg = pat[m_dig[e_idx]];
        e_an = ~(ND'(1) << e_idx);
      end
      committed = 0;
      if (pend && k == cmt_k) begin
        m_dig = p_dig;
        m_inv = p_inv;
        m_pm = p_pm;
        m_24 = p_24;
        pend = 0;
        committed = 1;
      end
      if (!pend && !committed && s_ld) begin
        model_load(s_vals, s_24);
        pend = 1;
        acc_k = k;
        cmt_k = k + 2 + 6 * NP;
      end
      e_busy = pend && k > acc_k;
      e_pm = m_pm;
    end
    if (started) begin
      chk("seg", bus.seg, e_seg);
      chk("an", bus.an, e_an);
      chk("busy", bus.busy, e_busy);
      chk("pm", bus.pm, e_pm);
      chk("an_onehot", $countones(~bus.an) <= 1, 1);
    end
  end

  task automatic do_load(logic [6*NP-1:0] v, bit s24);
    @(negedge clk);
    bus.values = v;
    bus.set24hours = s24;
    bus.load = 1;
    @(negedge clk);
    bus.load = 0;
  endtask

  task automatic wait_done(string nm);
    int n;
    n = 0;
    while (!bus.busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, n < 100, 1);
    repeat (2) @(negedge clk);
  endtask

  // Watch a full scan and compare each position to a literal.
  task automatic scan_check(string nm, logic [7*ND-1:0] e);
    bit seen [ND];
    logic [6:0] got [ND];
    for (int p = 0; p < ND; p++) begin
      seen[p] = 0;
      got[p] = 7'h7F;
    end
    repeat (2 * ND * RD + 6) begin
      @(negedge clk);
      for (int p = 0; p < ND; p++)
        if (!bus.an[p]) begin
          seen[p] = 1;
          got[p] = bus.seg;
        end
    end
    for (int p = 0; p < ND; p++)
      chk($sformatf("%s_d%0d", nm, p),
          seen[p] ? got[p] : 7'h7F, e[7*p +: 7]);
  endtask

  initial begin
    int nb, n0, n1;
    bus.values = '0;
    bus.set24hours = 0;
    bus.load = 0;
    bus.blink_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_an", bus.an, 6'h3F);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pm", bus.pm, 0);
    reset = 0;
    repeat (2) @(negedge clk);

    do_load(pack(13, 5, 59), 0);
    nb = 0;
    repeat (40) begin
      if (bus.busy) nb++;
      @(negedge clk);
    end
    chk("busy_len", nb, 19);
    scan_check("h13_12h", {7'h7F, 7'h79, 7'h40, 7'h12,
                           7'h12, 7'h10});
    chk("pm_h13_12h", bus.pm, 1);

    do_load(pack(13, 5, 59), 1);
    wait_done("h13_24h");
    scan_check("h13_24h", {7'h79, 7'h30, 7'h40, 7'h12,
                           7'h12, 7'h10});
    chk("pm_h13_24h", bus.pm, 0);

    do_load(pack(24, 5, 59), 1);
    wait_done("h24");
    scan_check("h24", {7'h40, 7'h40, 7'h40, 7'h12,
                       7'h12, 7'h10});

    do_load(pack(0, 5, 59), 0);
    wait_done("h0_12h");
    scan_check("h0_12h", {7'h79, 7'h24, 7'h40, 7'h12,
                          7'h12, 7'h10});
    chk("pm_h0_12h", bus.pm, 0);

    do_load(pack(13, 60, 59), 1);
    wait_done("m60");
    scan_check("m60", {7'h79, 7'h30, 7'h3F, 7'h3F,
                       7'h12, 7'h10});

    do_load(pack(10, 20, 30), 1);
    repeat (3) @(negedge clk);
    do_load(pack(1, 2, 3), 1);
    wait_done("busy_ld");
    scan_check("busy_ld", {7'h79, 7'h40, 7'h24, 7'h40,
                           7'h30, 7'h40});

    do_load(pack(13, 5, 59), 0);
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_seg", bus.seg, 7'h7F);
    chk("midrst_an", bus.an, 6'h3F);
    reset = 0;
    repeat (40) @(negedge clk);
    scan_check("midrst", {7'h40, 7'h40, 7'h40, 7'h40,
                          7'h40, 7'h40});
    chk("midrst_pm", bus.pm, 0);

    do_load(pack(13, 5, 59), 1);
    wait_done("blink");
    bus.blink_mask = 3'b010;
    n0 = 0;
    n1 = 0;
    repeat (96) begin
      @(negedge clk);
      if (!bus.an[0]) n0++;
      if (!bus.an[2] || !bus.an[3]) n1++;
    end
    chk("blink_p0", n0, 16);
    chk("blink_p1", n1, 16);
    bus.blink_mask = '0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised multi-digit seven-segment driver for the alarm clock.
- Takes NUM_PAIRS binary fields (hours/minutes/seconds, 0..59 each) and converts each to two BCD digits with a serial double-dabble engine.
- Applies 12/24-hour mapping to the hours pair, then time-multiplexes all 2*NUM_PAIRS digits onto one shared segment bus.
- Supports per-pair blinking for set mode and a PM indicator.
- Sits between the timekeeping/alarm registers and the board display pins.

Parameters:
NUM_PAIRS, 3, number of two-digit fields; pair 0 is least significant (rightmost).
HOURS_PAIR, 2, index of the pair that receives 12/24-hour mapping.
REFRESH_DIV, 100000, clk cycles each digit stays lit; must be ≥2.
BLINK_DIV, 25000000, clk cycles per blink half-period; must be ≥2.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
values  in  6*NUM_PAIRS  packed fields; pair k = values[6k+5:6k].
set24hours  in  1  1 = 24-hour display, 0 = 12-hour display; sampled on load.
load  in  1  single-cycle request to capture values and set24hours.
blink_mask  in  NUM_PAIRS  1 = pair k blinks.
busy  out  1  high while a conversion is in progress.
pm  out  1  12-hour mode PM flag; 0 in 24-hour mode.
seg  out  7  active-low segments, seg[0]=a … seg[6]=g.
an  out  2*NUM_PAIRS  active-low digit enables; an[2k]=ones, an[2k+1]=tens of pair k.

Behaviour:
Reset values
- seg=7'h7F, an all 1, pm=0, busy=0.
- Digit registers = 0; scan index = 0; refresh counter = 0; blink counter = 0; blink_phase = 0; FSM in IDLE.
- Reset in any state, including mid-conversion, aborts the conversion and applies all reset values in the same cycle.

Conversion FSM: IDLE → ADJUST → CONVERT → COMMIT → IDLE
- IDLE: when load=1, capture values and set24hours; go to ADJUST. busy rises on the next cycle.
- ADJUST (1 cycle): produce adjusted values and the pm shadow.
  - Hours pair, 12-hour mode: 0→12, pm=0; 1..11 unchanged, pm=0; 12→12, pm=1; 13..23→v-12, pm=1.
  - Hours pair, 24-hour mode: 24→0; pm=0.
  - Any pair with value >59 (after mapping) is flagged invalid.
- CONVERT (6 cycles per pair, pairs 0 upward, 6*NUM_PAIRS cycles total): standard shift-add-3 double dabble into 4-bit tens and ones shadow registers.
- COMMIT (1 cycle): copy all shadow digits, invalid flags and pm to the display registers atomically; busy=0 on the next cycle.
- Latency: load accepted at cycle T → display registers updated at T+2+6*NUM_PAIRS. A partial update is never visible.
- load while busy=1 is ignored, with no queueing.

Scan
- The refresh counter counts 0..REFRESH_DIV-1. On wrap, the scan index goes 0,1,…,2*NUM_PAIRS-1, then back to 0.
- seg and an are registered and change one cycle after the index changes. Exactly one an bit is low unless the digit is blanked.

Digit decode
- 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=all, 9=abcdfg.
- Invalid pair: both digits show a dash (g only, seg=7'h3F).

Blanking (digit's an bit stays high and seg=7'h7F)
- Blink: blink_phase toggles every BLINK_DIV cycles. A digit is blanked when blink_phase=1 and blink_mask for its pair is 1. blink_mask is sampled live, not on load.
- Leading zero: tens digit of HOURS_PAIR is blanked in 12-hour mode when it equals 0.

Test Plan:
- Reset, then NUM_PAIRS=3, values={h=13,m=5,s=59}, set24hours=0, load → busy high for exactly 19 cycles; after commit the scan shows digits 9,5,5,0,1,blank (tens of hours blanked); pm=1.
- Same values with set24hours=1 → digits 9,5,5,0,3,1; pm=0. Hours=24 → "00". Hours=0 in 12-hour mode → "12", pm=0.
- Minutes=60 → pair 1 shows seg=7'h3F on both digits; other pairs correct.
- load pulsed during busy → ignored; display matches the first load only. Reset at the 5th CONVERT cycle → busy=0, all digits show 0, seg/an at reset values for one cycle.
- REFRESH_DIV=4, BLINK_DIV=16, blink_mask=3'b010 → an cycles one-hot every 4 clocks; an[2], an[3] stay high while blink_phase=1, and pairs 0 and 2 are unaffected.
- Scan index wraps from 5 to 0; an never has two bits low in any cycle.
